// File: rtl/mem.sv
// mem: single-port 2**ADDR_W x DATA_W storage array with registered read port.
// Latency: write lands on the sampling edge; read data appears on data_o one edge after the request.
// Backpressure: none; busy_o (post-reset clear sweep, MEM_CLEAR_ON_RESET_EN builds only) drops accesses while high.
module mem #(
  parameter int unsigned DATA_W = 256,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [ADDR_W-1:0] address_i,
  input  logic              en_i,
  input  logic              rw_i,
  output logic [DATA_W-1:0] data_o,
  output logic              busy_o
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  // Storage is never reset; only the optional sweep writes zeros into it.
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [DATA_W-1:0] data_q, data_d;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_dat;
  logic              busy;

`ifdef MEM_CLEAR_ON_RESET_EN
  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  // Sweep sequencing: walk every address once, leave after the last one.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == CLEAR) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == {ADDR_W{1'b1}}) begin
        state_d = IDLE;
      end
    end
  end

  // Sweep state; any reset (including mid-sweep) restarts from address 0.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == CLEAR);
`else
  assign busy = 1'b0;
`endif

  // Port arbitration: reset blocks everything, the sweep owns the array while busy,
  // otherwise the user request decides between a write and a registered read.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = address_i;
    wr_dat  = data_i;
    data_d  = data_q;
    if (rst_i) begin
      data_d = '0;
    end else if (busy) begin
`ifdef MEM_CLEAR_ON_RESET_EN
      wr_en   = 1'b1;
      wr_addr = cnt_q;
      wr_dat  = '0;
`endif
    end else if (en_i) begin
      if (rw_i) begin
        data_d = mem_q[address_i];
      end else begin
        wr_en = 1'b1;
      end
    end
  end

  // Read data register; cleared by reset and otherwise held between reads.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  // Array write port, shared by user writes and the clear sweep.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_dat;
    end
  end

  assign data_o = data_q;
  assign busy_o = busy;

endmodule

// File: tb/tb_mem.sv
// tb_mem: randomized and directed checks of mem against an associative-array model.
// Latency: inputs driven and outputs sampled 1ns after each rising edge.
// Backpressure: clear-sweep builds wait on busy_o with a bounded cycle budget.
module tb_mem;

  localparam int DATA_W = 256;
  localparam int ADDR_W = 8;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b0;
  logic [DATA_W-1:0] data_i = '0;
  logic [ADDR_W-1:0] address_i = '0;
  logic              en_i = 1'b0;
  logic              rw_i = 1'b0;
  logic [DATA_W-1:0] data_o;
  logic              busy_o;

  mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .data_i    (data_i),
    .address_i (address_i),
    .en_i      (en_i),
    .rw_i      (rw_i),
    .data_o    (data_o),
    .busy_o    (busy_o)
  );

  always #5 clk_i = ~clk_i;

`ifdef MEM_CLEAR_ON_RESET_EN
  localparam logic CLR_EN = 1'b1;
`else
  localparam logic CLR_EN = 1'b0;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Reference: contents of every address written so far (absent = undefined).
  logic [DATA_W-1:0] model [int];
  logic [DATA_W-1:0] exp_dout;
  logic              exp_known;

  task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [DATA_W-1:0] rand_word();
    logic [DATA_W-1:0] w;
    for (int i = 0; i < DATA_W / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic do_reset();
    rst_i = 1'b1;
    en_i  = 1'b0;
    tick();
    rst_i = 1'b0;
    exp_dout  = '0;
    exp_known = 1'b1;
    if (CLR_EN) begin
      for (int i = 0; i < 256; i++) model[i] = '0;
    end
    check("rst_data", data_o, '0);
    check("rst_busy", {255'b0, busy_o}, {255'b0, CLR_EN});
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    en_i = 1'b1; rw_i = 1'b0; address_i = a; data_i = d;
    tick();
    en_i = 1'b0;
    model[int'(a)] = d;
    if (exp_known) check("wr_hold", data_o, exp_dout);
  endtask

  task automatic do_read(input string tag, input logic [ADDR_W-1:0] a);
    en_i = 1'b1; rw_i = 1'b1; address_i = a;
    tick();
    en_i = 1'b0;
    exp_known = model.exists(int'(a));
    if (exp_known) begin
      exp_dout = model[int'(a)];
      check(tag, data_o, exp_dout);
    end
  endtask

  // Counts cycles until busy_o drops; optionally pokes accesses that must be ignored.
  task automatic wait_clear(input string tag, input int stop_at, output int cnt);
    cnt = 0;
    while (busy_o && cnt < 400 && cnt != stop_at) begin
      en_i = 1'b1; rw_i = cnt[0]; address_i = 8'd8; data_i = 256'd5;
      tick();
      en_i = 1'b0;
      cnt++;
      if (cnt == 17) check({tag, "_busy_data0"}, data_o, '0);
    end
    en_i = 1'b0;
  endtask

  initial begin
    int c;
    logic [DATA_W-1:0] ones;
    exp_dout  = '0;
    exp_known = 1'b0;
    ones      = '1;

    // Power-up reset.
    do_reset();
`ifdef MEM_CLEAR_ON_RESET_EN
    wait_clear("clr0", -1, c);
    check("clr0_cycles", DATA_W'(c), DATA_W'(256));
`endif

    // Directed write/read/hold/disable.
    do_write(8'd8, 256'd1337);
    do_read("rd8", 8'd8);
    check("rd8_val", data_o, 256'd1337);
    tick();
    check("rd8_hold", data_o, 256'd1337);
    en_i = 1'b0; rw_i = 1'b0; address_i = 8'd8; data_i = 256'd5;
    tick();
    check("dis_hold", data_o, 256'd1337);
    do_read("dis_rd8", 8'd8);
    check("dis_val", data_o, 256'd1337);

    // Boundary addresses and full-width patterns.
    do_write(8'd255, ones);
    do_write(8'd0, 256'd1);
    do_read("rd255", 8'd255);
    check("rd255_val", data_o, ones);
    do_read("rd0", 8'd0);
    check("rd0_val", data_o, 256'd1);
    do_read("rd8_again", 8'd8);

    // Randomized traffic, with hold checks on idle/write cycles.
    for (int i = 0; i < 400; i++) begin
      logic [ADDR_W-1:0] a;
      int op;
      case ($urandom_range(0, 3))
        0: a = 8'd0;
        1: a = 8'd255;
        2: a = 8'($urandom_range(0, 7));
        default: a = 8'($urandom);
      endcase
      op = $urandom_range(0, 2);
      if (op == 0) do_write(a, rand_word());
      else if (op == 1) do_read("rnd_rd", a);
      else begin
        en_i = 1'b0; rw_i = 1'($urandom); address_i = a; data_i = rand_word();
        tick();
        if (exp_known) check("rnd_idle_hold", data_o, exp_dout);
      end
    end

    // Reset with known content at address 8.
    do_write(8'd8, 256'd1337);
    do_read("pre_rst8", 8'd8);
    do_reset();
`ifdef MEM_CLEAR_ON_RESET_EN
    wait_clear("clr1", -1, c);
    check("clr1_cycles", DATA_W'(c), DATA_W'(256));
    do_read("clr1_rd8", 8'd8);
    check("clr1_rd8_zero", data_o, '0);

    // Reset arriving 100 cycles into a sweep restarts it.
    do_write(8'd77, ones);
    do_reset();
    wait_clear("clr2a", 100, c);
    check("clr2a_busy", {255'b0, busy_o}, 256'd1);
    do_reset();
    wait_clear("clr2b", -1, c);
    check("clr2_cycles", DATA_W'(c), DATA_W'(256));
    for (int i = 0; i < 256; i++) do_read("clr2_rd", 8'(i));
`else
    check("keep_busy", {255'b0, busy_o}, '0);
    do_read("keep_rd8", 8'd8);
    check("keep_rd8_val", data_o, 256'd1337);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
